// File: rtl/mest_pkg.sv
// Shared sizes, NOP encoding and loader FSM states for the program memory block.
package mest_pkg;
  localparam int OP_CODE_SIZE     = 4;
  localparam int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8;
  localparam int ROM_DEPTH        = 256;

  localparam logic [INSTRUCTION_SIZE-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } mest_state_e;
endpackage

// File: rtl/mest_sp_ram.sv
// Single-port instruction store: synchronous write, synchronous read that only updates on i_re.
module mest_sp_ram #(
  parameter int DW    = 28,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) rdata_q <= mem[i_addr];
  end

  assign o_rdata = rdata_q;
endmodule

// File: rtl/mest_prog_mem.sv
// Program memory: host loads words into the store, then the processor fetches with 1-cycle latency.
module mest_prog_mem #(
  parameter int OP_CODE_SIZE     = mest_pkg::OP_CODE_SIZE,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
  parameter int ROM_DEPTH        = mest_pkg::ROM_DEPTH,
  localparam int AW              = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_load_valid,
  input  logic [INSTRUCTION_SIZE-1:0] i_load_data,
  input  logic                        i_load_last,
  output logic                        o_load_ready,
  output logic                        o_loaded,
  output logic [AW:0]                 o_prog_len,
  input  logic                        i_req,
  input  logic [AW-1:0]               i_prog_counter,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_instr_valid,
  output logic                        o_addr_error
);
  import mest_pkg::*;

  localparam logic [AW:0] LAST_WP = (AW+1)'(ROM_DEPTH - 1);

  mest_state_e                 state_q;
  logic [AW:0]                 wp_q;
  logic                        pend_q;
  logic [AW-1:0]               pend_addr_q;
  logic                        vld_q, err_q;
  logic [INSTRUCTION_SIZE-1:0] last_q;

  logic                        accept, serve_pend, serve_req, rd_go, rd_err;
  logic                        ram_we, ram_re;
  logic [AW-1:0]               rd_addr, ram_addr;
  logic [INSTRUCTION_SIZE-1:0] ram_rdata;

  always_comb begin
    accept     = i_load_valid && (state_q != ST_READY);
    // A held request goes ahead of a new one so responses stay in request order.
    serve_pend = (state_q == ST_READY) && pend_q;
    serve_req  = (state_q == ST_READY) && i_req && !pend_q;
    rd_addr    = serve_pend ? pend_addr_q : i_prog_counter;
    rd_go      = (serve_pend || serve_req) && !i_clear;
    rd_err     = ({1'b0, rd_addr} >= wp_q);
    ram_we     = accept && !i_clear && !i_reset;
    ram_re     = rd_go && !rd_err && !i_reset;
    ram_addr   = ram_we ? wp_q[AW-1:0] : rd_addr;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= ST_EMPTY;
      wp_q        <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= '0;
    end else begin
      last_q <= o_instruction;
      vld_q  <= rd_go;
      err_q  <= rd_go && rd_err;
      if (i_clear) begin
        state_q <= ST_EMPTY;
        wp_q    <= '0;
        pend_q  <= 1'b0;
      end else begin
        if (accept) begin
          wp_q    <= wp_q + 1'b1;
          state_q <= (i_load_last || wp_q == LAST_WP) ? ST_READY : ST_LOADING;
        end
        if (state_q == ST_READY) begin
          // A new request arriving while the held one drains takes its slot.
          if (serve_pend) begin
            pend_q      <= i_req;
            pend_addr_q <= i_prog_counter;
          end
        end else if (i_req) begin
          pend_q      <= 1'b1;
          pend_addr_q <= i_prog_counter;
        end
      end
    end
  end

  mest_sp_ram #(
    .DW    (INSTRUCTION_SIZE),
    .DEPTH (ROM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (ram_addr),
    .i_wdata (i_load_data),
    .o_rdata (ram_rdata)
  );

  assign o_load_ready  = (state_q != ST_READY);
  assign o_loaded      = (state_q == ST_READY);
  assign o_prog_len    = wp_q;
  assign o_instr_valid = vld_q;
  assign o_addr_error  = vld_q && err_q;
  assign o_instruction = vld_q ? (err_q ? INSTRUCTION_SIZE'(NOP) : ram_rdata) : last_q;
endmodule

// File: tb/tb_mest_prog_mem.sv
// Directed bench for mest_prog_mem: expected fetch responses are queued at issue and checked by a monitor.
module tb_mest_prog_mem;
  logic        clk = 1'b0;
  logic        i_reset, i_clear, i_load_valid, i_load_last, i_req;
  logic [27:0] i_load_data;
  logic [7:0]  i_prog_counter;
  logic        o_load_ready, o_loaded, o_instr_valid, o_addr_error;
  logic [8:0]  o_prog_len;
  logic [27:0] o_instruction;

  always #5 clk = ~clk;

  mest_prog_mem dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_clear        (i_clear),
    .i_load_valid   (i_load_valid),
    .i_load_data    (i_load_data),
    .i_load_last    (i_load_last),
    .o_load_ready   (o_load_ready),
    .o_loaded       (o_loaded),
    .o_prog_len     (o_prog_len),
    .i_req          (i_req),
    .i_prog_counter (i_prog_counter),
    .o_instruction  (o_instruction),
    .o_instr_valid  (o_instr_valid),
    .o_addr_error   (o_addr_error)
  );

  typedef struct packed {
    logic [27:0] ins;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   mis = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [27:0] d, input logic last);
    i_load_valid = 1'b1;
    i_load_data  = d;
    i_load_last  = last;
    step();
    i_load_valid = 1'b0;
    i_load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] pc, input logic [27:0] e, input logic err);
    i_req          = 1'b1;
    i_prog_counter = pc;
    q.push_back('{ins: e, err: err});
    step();
    i_req = 1'b0;
  endtask

  task automatic status(input string tag, input logic rdy, input logic ld, input logic [8:0] len);
    chk({tag, ".load_ready"}, 32'(o_load_ready), 32'(rdy));
    chk({tag, ".loaded"},     32'(o_loaded),     32'(ld));
    chk({tag, ".prog_len"},   32'(o_prog_len),   32'(len));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (o_instr_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(o_instr_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("instr",    32'(o_instruction), 32'(e.ins));
          chk("addr_err", 32'(o_addr_error),  32'(e.err));
        end
      end else if (o_addr_error !== 1'b0) begin
        chk("stray_addr_err", 32'(o_addr_error), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_clear = 1'b0; i_load_valid = 1'b0; i_load_last = 1'b0;
    i_load_data = '0; i_req = 1'b0; i_prog_counter = '0;
    step(); step();
    i_reset = 1'b0;
    status("reset", 1'b1, 1'b0, 9'd0);
    chk("reset.instr", 32'(o_instruction), 32'd0);
    chk("reset.valid", 32'(o_instr_valid), 32'd0);
    chk("reset.err",   32'(o_addr_error),  32'd0);
    mon_on = 1'b1;

    // Three-word program, then back-to-back fetches.
    load_word(28'h1000001, 1'b0);
    status("load1", 1'b1, 1'b0, 9'd1);
    load_word(28'h2000002, 1'b0);
    load_word(28'h3000003, 1'b1);
    status("load3", 1'b0, 1'b1, 9'd3);
    fetch(8'd0, 28'h1000001, 1'b0);
    fetch(8'd1, 28'h2000002, 1'b0);
    fetch(8'd2, 28'h3000003, 1'b0);
    step(); step();

    // Out-of-range fetch returns NOP with a one-cycle error pulse.
    fetch(8'd5, 28'h0, 1'b1);
    step(); step();

    // Host words in READY are ignored.
    load_word(28'hABCDEF0, 1'b0);
    status("ready_ignore", 1'b0, 1'b1, 9'd3);
    fetch(8'd1, 28'h2000002, 1'b0);
    step();
    fetch(8'd2, 28'h3000003, 1'b0);
    fetch(8'd3, 28'h0, 1'b1);
    step(); step();

    // Clear wins over a simultaneous request.
    i_clear = 1'b1; i_req = 1'b1; i_prog_counter = 8'd0;
    step();
    i_clear = 1'b0; i_req = 1'b0;
    status("clear", 1'b1, 1'b0, 9'd0);
    chk("clear.valid", 32'(o_instr_valid), 32'd0);
    step(); step();

    // Request held during LOADING is served right after READY.
    load_word(28'hA0A0A0A, 1'b0);
    status("pend_load", 1'b1, 1'b0, 9'd1);
    fetch(8'd1, 28'h5555555, 1'b0);
    load_word(28'h5555555, 1'b1);
    status("pend_ready", 1'b0, 1'b1, 9'd2);
    chk("pend.not_yet", 32'(o_instr_valid), 32'd0);
    step();
    chk("pend.valid", 32'(o_instr_valid), 32'd1);
    chk("pend.data",  32'(o_instruction), 32'h5555555);
    step(); step();

    // Full-depth load without last.
    i_clear = 1'b1; step(); i_clear = 1'b0;
    for (int i = 0; i < 256; i++) load_word(28'(i + 'h100), 1'b0);
    status("full", 1'b0, 1'b1, 9'd256);
    load_word(28'hFFFFFFF, 1'b0);
    status("full_ignore", 1'b0, 1'b1, 9'd256);
    fetch(8'd255, 28'h1FF, 1'b0);
    fetch(8'd0,   28'h100, 1'b0);
    fetch(8'd128, 28'h180, 1'b0);
    step(); step();

    // Reset in the middle of a load with a request pending.
    i_clear = 1'b1; step(); i_clear = 1'b0;
    load_word(28'h0000077, 1'b0);
    i_req = 1'b1; i_prog_counter = 8'd0;
    step();
    i_req = 1'b0;
    i_reset = 1'b1; i_load_valid = 1'b1; i_load_data = 28'h0000088; i_load_last = 1'b1;
    step();
    i_reset = 1'b0; i_load_valid = 1'b0; i_load_last = 1'b0;
    status("midreset", 1'b1, 1'b0, 9'd0);
    chk("midreset.instr", 32'(o_instruction), 32'd0);
    chk("midreset.valid", 32'(o_instr_valid), 32'd0);
    chk("midreset.err",   32'(o_addr_error),  32'd0);
    step(); step(); step();

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
